shift_right_iter: RTL and testbench
===================================

Name: shift_right_iter

Overview:
- Multi-cycle right-shift unit for the MIPS datapath: performs SRL/SRA (and their variable forms SRLV/SRAV) on a 32-bit operand.
- Shifts by up to STEP bits per clock, with a start/busy/done handshake.
- Complements the registered left-shift path; sits beside the ALU and is stalled on by the control unit while busy.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHW, 5, shift-amount width (clog2(WIDTH)).
- STEP, 1, max bits shifted per cycle; legal values 1, 2, 4, 8.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- in  input  WIDTH  operand, captured on the accepted start edge.
- shamt  input  SHW  shift amount 0..WIDTH-1, captured with in.
- arith  input  1  1=arithmetic (sign fill, SRA), 0=logical (zero fill, SRL); captured with in.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when out is updated.
- out  output  WIDTH  result, held until the next completion.

Behaviour:
- One clock, named clock; reset is asynchronous and active-low, named reset_n. All flops reset immediately on reset_n=0.
- Reset values: busy=0, done=0, out=0, state=IDLE, internal data=0, count=0.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge E0:
  - data<=in, cnt<=shamt, fill<=arith & in[WIDTH-1], state<=SHIFT.
  - busy=1 from E0.
- SHIFT, each edge with cnt!=0:
  - k=min(STEP,cnt); data<=data>>k, with top k bits = fill; cnt<=cnt-k.
- SHIFT, edge with cnt==0:
  - out<=data, done<=1 for exactly one cycle, busy<=0, state<=IDLE.
- Latency: done is high after edge E0+ceil(shamt/STEP)+1.
  - shamt=0 gives 1 cycle; STEP=1, shamt=31 gives 32 cycles.
- done deasserts on the next edge unconditionally.
- start while busy=1 is ignored; no queuing, and the in operand is not re-sampled.
- Back-to-back: start is legal in the cycle done is high (state already IDLE). It is accepted at that edge and busy rises again.
- arith=0: result = in >> shamt, zero filled.
- arith=1: result = signed(in) >>> shamt, filled with the sign captured at E0.
- shamt is treated modulo WIDTH by width; no out-of-range value exists.
- Reset mid-operation: operation aborted, no done pulse, out=0; first start after reset_n deasserts is accepted normally.
- in, shamt and arith may change freely after E0 without effect.

Decomposition:
- Shared package shift_pkg:
  - state encoding (IDLE, SHIFT).
  - constants WIDTH_DEFAULT=32, SHW_DEFAULT=5.
- Natural sub-module shift_right_step: combinational, data/fill/k in, shifted data out, k up to STEP. Instantiated once.
- Control (FSM, counter, handshake) stays in shift_right_iter.

Test Plan:
- Logical shift, STEP=1: in=32'hF000_0000, shamt=4, arith=0 -> done 5 cycles after start, out=32'h0F00_0000, busy high for exactly those 5 cycles.
- Arithmetic shift, STEP=1: in=32'h8000_0010, shamt=4, arith=1 -> out=32'hF800_0001. Repeat with arith=0 -> out=32'h0800_0001.
- Zero and maximum shift: shamt=0, in=32'h1234_5678 -> done 1 cycle after start, out=32'h1234_5678. STEP=4, shamt=31, in=32'hFFFF_FFFF, arith=0 -> done after 9 cycles, out=32'h0000_0001.
- Handshake:
  - start held high while busy, with in changed to 32'hDEAD_BEEF mid-op -> result unaffected, single done.
  - start asserted in the done cycle (in=32'h0000_0100, shamt=8) -> accepted, next out=32'h0000_0001.
- Reset mid-operation: assert reset_n=0 asynchronously (between edges) 3 cycles into a shamt=20 op -> busy, done, out=0 immediately; no done pulse afterwards; a fresh op completes correctly.
- Randomised sweep: all shamt 0..31, both arith values, STEP in {1,2,4,8} -> out matches reference >>/>>>, and latency = ceil(shamt/STEP)+1.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the iterative right-shift unit.
package shift_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int SHW_DEFAULT   = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_right_step.sv
// One combinational right-shift step: shifts data right by k and fills the vacated top bits.
module shift_right_step #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic [WIDTH-1:0] data,
  input  logic             fill,
  input  logic [SHW-1:0]   k,
  output logic [WIDTH-1:0] shifted
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] top_mask;

  // Mask covering the k vacated MSBs.
  assign top_mask = ~(ONES >> k);
  assign shifted  = (data >> k) | ({WIDTH{fill}} & top_mask);

endmodule

// File: rtl/shift_right_iter.sv
// Multi-cycle SRL/SRA unit: shifts up to STEP bits per clock with a start/busy/done handshake.
module shift_right_iter
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SHW   = SHW_DEFAULT,
  parameter int STEP  = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic [SHW-1:0]   k;
  logic [WIDTH-1:0] step_data;

  assign k = (cnt_q < STEP_W) ? cnt_q : STEP_W;

  shift_right_step #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_step (
    .data   (data_q),
    .fill   (fill_q),
    .k      (k),
    .shifted(step_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = in;
          cnt_d   = shamt;
          fill_d  = arith & in[WIDTH-1];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          data_d = step_data;
          cnt_d  = cnt_q - k;
        end else begin
          out_d   = data_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // busy follows the state so it drops in the done cycle, allowing back-to-back starts.
  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_shift_right_iter.sv
// Self-checking bench: four instances (STEP=1,2,4,8) driven in parallel against a >>/>>> reference.
module tb_shift_right_iter;

  localparam int N = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] op_in;
  logic [4:0]  shamt;
  logic        arith;
  logic [N-1:0] busy_v;
  logic [N-1:0] done_v;
  logic [31:0] out_v [N];

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    shift_right_iter #(
      .WIDTH(32),
      .SHW  (5),
      .STEP (1 << g)
    ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .start  (start),
      .in     (op_in),
      .shamt  (shamt),
      .arith  (arith),
      .busy   (busy_v[g]),
      .done   (done_v[g]),
      .out    (out_v[g])
    );
  end

  typedef struct {
    logic [31:0] a;
    logic [4:0]  s;
    logic        ar;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s, input logic ar);
    if (ar) return 32'($signed(a) >>> s);
    return a >> s;
  endfunction

  function automatic int exp_lat(input int s, input int step);
    return (s + step - 1) / step + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One operation on all instances; checks latency, busy length, single done, result.
  task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic ar,
                        input logic [31:0] exp);
    int          lat [N];
    int          bcnt[N];
    int          dcnt[N];
    logic [31:0] res [N];
    @(negedge clock);
    op_in = a; shamt = s; arith = ar; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    op_in = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
    for (int i = 0; i < N; i++) begin
      lat[i] = -1; bcnt[i] = int'(busy_v[i]); dcnt[i] = 0; res[i] = '0;
    end
    for (int c = 1; c <= 35; c++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (busy_v[i]) bcnt[i]++;
        if (done_v[i]) begin
          dcnt[i]++;
          if (lat[i] < 0) begin
            lat[i] = c;
            res[i] = out_v[i];
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      check($sformatf("out step%0d in=%h sh=%0d ar=%0d", 1 << i, a, s, ar), res[i], exp);
      check($sformatf("latency step%0d sh=%0d", 1 << i, s), 32'(lat[i]), 32'(exp_lat(int'(s), 1 << i)));
      check($sformatf("busy_len step%0d sh=%0d", 1 << i, s), 32'(bcnt[i]), 32'(exp_lat(int'(s), 1 << i)));
      check($sformatf("done_count step%0d sh=%0d", 1 << i, s), 32'(dcnt[i]), 32'd1);
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy_v != '0 && c < 50) begin
      @(posedge clock);
      #1;
      c++;
    end
    check("idle_timeout", 32'(busy_v), 32'd0);
    @(posedge clock);
    #1;
  endtask

  vec_t vecs [6];

  initial begin
    int          c;
    int          dseen;
    logic [31:0] first_out;

    vecs[0] = '{32'hF000_0000, 5'd4,  1'b0, 32'h0F00_0000};
    vecs[1] = '{32'h8000_0010, 5'd4,  1'b1, 32'hF800_0001};
    vecs[2] = '{32'h8000_0010, 5'd4,  1'b0, 32'h0800_0001};
    vecs[3] = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678};
    vecs[4] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0000_0001};
    vecs[5] = '{32'hFFFF_FFFF, 5'd31, 1'b1, 32'hFFFF_FFFF};

    reset_n = 1'b0; start = 1'b0; op_in = '0; shamt = '0; arith = 1'b0;
    #12;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset busy%0d", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("reset done%0d", i), 32'(done_v[i]), 32'd0);
      check($sformatf("reset out%0d", i), out_v[i], 32'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;

    for (int t = 0; t < 6; t++) run_op(vecs[t].a, vecs[t].s, vecs[t].ar, vecs[t].exp);

    // Start held high while busy, in changed mid-op, then back-to-back start in the done cycle (STEP=1).
    @(negedge clock);
    op_in = 32'h00F0_0000; shamt = 5'd8; arith = 1'b0; start = 1'b1;
    @(posedge clock);
    #1;
    dseen = 0; c = 0; first_out = '0;
    while (dseen == 0 && c < 40) begin
      @(posedge clock);
      #1;
      c++;
      if (c == 3) op_in = 32'hDEAD_BEEF;
      if (done_v[0]) begin
        dseen = 1;
        first_out = out_v[0];
      end
    end
    check("hold_start result", first_out, 32'h0000_F000);
    check("hold_start latency", 32'(c), 32'd9);
    op_in = 32'h0000_0100; shamt = 5'd8;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("b2b busy", 32'(busy_v[0]), 32'd1);
    check("b2b done_clears", 32'(done_v[0]), 32'd0);
    dseen = 0; c = 0;
    while (dseen == 0 && c < 40) begin
      @(posedge clock);
      #1;
      c++;
      if (done_v[0]) dseen = 1;
    end
    check("b2b result", out_v[0], 32'h0000_0001);
    check("b2b latency", 32'(c), 32'd9);
    wait_idle();

    // Asynchronous reset three cycles into a shamt=20 op.
    @(negedge clock);
    op_in = 32'h8765_4321; shamt = 5'd20; arith = 1'b1; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("midreset busy%0d", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("midreset done%0d", i), 32'(done_v[i]), 32'd0);
      check($sformatf("midreset out%0d", i), out_v[i], 32'd0);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    dseen = 0;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (done_v != '0) dseen++;
    end
    check("no_done_after_reset", 32'(dseen), 32'd0);

    // Sweep every shift amount in both modes with random operands.
    for (int s = 0; s < 32; s++) begin
      for (int ar = 0; ar < 2; ar++) begin
        logic [31:0] a;
        a = $urandom;
        if (ar == 1 && s[0]) a[31] = 1'b1;
        run_op(a, 5'(s), 1'(ar), model(a, 5'(s), 1'(ar)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
